// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter that merges CHANNELS AXI4-Stream sources into one registered sink.
// Each grant is held for up to cfg_burst words, and the source index is tagged on tuser.
module axis_rr_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int CHANNELS    = 4,
   parameter int BURST_WIDTH = 8
) (
   input  logic                           aclk,
   input  logic                           areset,
   input  logic [BURST_WIDTH-1:0]         cfg_burst,
   input  logic [CHANNELS-1:0]            cfg_mask,
   input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [CHANNELS-1:0]            s_axis_tvalid,
   output logic [CHANNELS-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]          m_axis_tdata,
   output logic [$clog2(CHANNELS)-1:0]    m_axis_tuser,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           sts_busy
);

   localparam int IDX_W = $clog2(CHANNELS);

   typedef enum logic {IDLE, GRANT} state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic [IDX_W-1:0]       user_q, user_d;
   logic                   valid_q, valid_d;

   logic [DATA_WIDTH-1:0]  src_data [CHANNELS];
   logic [CHANNELS-1:0]    eligible;
   logic [IDX_W-1:0]       pick;
   logic [IDX_W-1:0]       cand;
   logic                   found;
   logic                   can_load;
   logic                   xfer;

   always_comb begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Search upward from last+1 so the previous winner has the lowest priority.
   always_comb begin
      eligible = s_axis_tvalid & cfg_mask;
      pick     = last_q;
      cand     = '0;
      found    = 1'b0;
      for (int unsigned i = 1; i <= CHANNELS; i++) begin
         cand = IDX_W'((32'(last_q) + i) % CHANNELS);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign can_load = ~valid_q | m_axis_tready;

   always_comb begin
      s_axis_tready = '0;
      if (state_q == GRANT) begin
         s_axis_tready[grant_q] = can_load & cfg_mask[grant_q];
      end
   end

   assign xfer = (state_q == GRANT) & s_axis_tvalid[grant_q] & s_axis_tready[grant_q];

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      user_d  = user_q;
      valid_d = valid_q & ~m_axis_tready;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = pick;
               last_d  = pick;
               cnt_d   = (cfg_burst == '0) ? BURST_WIDTH'(1) : cfg_burst;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (xfer) begin
               data_d  = src_data[grant_q];
               user_d  = grant_q;
               valid_d = 1'b1;
               cnt_d   = cnt_q - BURST_WIDTH'(1);
            end
            // A dry source only ends the grant when the output could have accepted a word.
            if ((xfer && cnt_q == BURST_WIDTH'(1)) ||
                (can_load && !s_axis_tvalid[grant_q]) ||
                !cfg_mask[grant_q]) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(CHANNELS - 1);
         cnt_q   <= '0;
         data_q  <= '0;
         user_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         user_q  <= user_d;
         valid_q <= valid_d;
      end
   end

   assign m_axis_tdata  = data_q;
   assign m_axis_tuser  = user_q;
   assign m_axis_tvalid = valid_q;
   assign sts_busy      = (state_q == GRANT);

endmodule
